// File: rtl/cache_line_burst_adapter.sv
// Cache-line burst adapter: turns one line fill or writeback request into a
// sequence of single-word memory beats, optionally critical-word-first on fills.
module cache_line_burst_adapter #(
   parameter int WORD_SIZE       = 32,
   parameter int WORDS_PER_LINE  = 8,
   parameter int ADDR_WIDTH      = 32,
   parameter int CRIT_WORD_FIRST = 0
) (
   input  logic                                clk,
   input  logic                                clr,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic                                req_wb,
   input  logic [ADDR_WIDTH-1:0]               req_addr,
   input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_wdata,
   output logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_rdata,
   output logic                                done,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   output logic                                mem_re,
   output logic                                mem_we,
   output logic [WORD_SIZE-1:0]                mem_wdata,
   input  logic [WORD_SIZE-1:0]                mem_rdata,
   input  logic                                mem_ack
);

   localparam int BYTE_BITS   = $clog2(WORD_SIZE / 8);
   localparam int LINE_BITS   = $clog2(WORDS_PER_LINE);
   localparam int OFFSET_BITS = BYTE_BITS + LINE_BITS;
   localparam logic [LINE_BITS-1:0] LAST_BEAT = LINE_BITS'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, FILL, WB, DONE} state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   base;
   logic [ADDR_WIDTH-1:0]   beat_addr;
   logic [LINE_BITS-1:0]    index;
   logic [LINE_BITS-1:0]    beat;
   logic [WORD_SIZE-1:0]    buffer [WORDS_PER_LINE];
   logic                    accept;
   logic                    beat_done;
   logic                    unused_addr_bits;

   assign accept    = (state == IDLE) && req_valid;
   assign beat_done = ((state == FILL) || (state == WB)) && mem_ack;
   assign beat_addr = base + (ADDR_WIDTH'(index) << BYTE_BITS);
   // Byte-offset bits of req_addr only matter through the word index.
   assign unused_addr_bits = ^req_addr;

   always_ff @(posedge clk) begin
      if (clr)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      done       = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_next = req_wb ? WB : FILL;
         end
         FILL: begin
            mem_re   = 1'b1;
            mem_addr = beat_addr;
            if (mem_ack && (beat == LAST_BEAT))
               state_next = DONE;
         end
         WB: begin
            mem_we    = 1'b1;
            mem_addr  = beat_addr;
            mem_wdata = buffer[index];
            if (mem_ack && (beat == LAST_BEAT))
               state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Index wraps naturally because it is exactly LINE_BITS wide.
   always_ff @(posedge clk) begin
      if (clr) begin
         base  <= '0;
         beat  <= '0;
         index <= '0;
      end else if (accept) begin
         base  <= {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
         beat  <= '0;
         index <= ((CRIT_WORD_FIRST != 0) && !req_wb) ?
                  req_addr[OFFSET_BITS-1:BYTE_BITS] : '0;
      end else if (beat_done) begin
         beat  <= beat + LINE_BITS'(1);
         index <= index + LINE_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         if (accept && req_wb) begin
            for (int i = 0; i < WORDS_PER_LINE; i++)
               buffer[i] <= line_wdata[i*WORD_SIZE +: WORD_SIZE];
         end else if (beat_done && (state == FILL)) begin
            buffer[index] <= mem_rdata;
         end
      end
   end

   for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_pack
      assign line_rdata[g*WORD_SIZE +: WORD_SIZE] = buffer[g];
   end

endmodule

// File: tb/tb_cache_line_burst_adapter.sv
// Randomized self-checking bench: two 32-bit/8-word adapters (normal and
// critical-word-first) run in lock-step, plus a 64-bit/4-word adapter.
module tb_cache_line_burst_adapter;

   localparam int N  = 8;
   localparam int WS = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           clr;
   logic           req_valid, req_wb, mem_ack;
   logic [AW-1:0]  req_addr;
   logic [255:0]   line_wdata;

   logic           req_ready0, done0, mem_re0, mem_we0;
   logic [AW-1:0]  mem_addr0;
   logic [WS-1:0]  mem_wdata0, mem_rdata0;
   logic [255:0]   line_rdata0;

   logic           req_ready1, done1, mem_re1, mem_we1;
   logic [AW-1:0]  mem_addr1;
   logic [WS-1:0]  mem_wdata1, mem_rdata1;
   logic [255:0]   line_rdata1;

   logic           req_valid2, req_wb2, mem_ack2;
   logic [AW-1:0]  req_addr2;
   logic [255:0]   line_wdata2;
   logic           req_ready2, done2, mem_re2, mem_we2;
   logic [AW-1:0]  mem_addr2;
   logic [63:0]    mem_wdata2, mem_rdata2;
   logic [255:0]   line_rdata2;

   int checks   = 0;
   int failures = 0;

   cache_line_burst_adapter #(.WORD_SIZE(32), .WORDS_PER_LINE(8), .ADDR_WIDTH(32), .CRIT_WORD_FIRST(0)) dut0 (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready0), .req_wb(req_wb),
      .req_addr(req_addr), .line_wdata(line_wdata), .line_rdata(line_rdata0), .done(done0),
      .mem_addr(mem_addr0), .mem_re(mem_re0), .mem_we(mem_we0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata0), .mem_ack(mem_ack));

   cache_line_burst_adapter #(.WORD_SIZE(32), .WORDS_PER_LINE(8), .ADDR_WIDTH(32), .CRIT_WORD_FIRST(1)) dut1 (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready1), .req_wb(req_wb),
      .req_addr(req_addr), .line_wdata(line_wdata), .line_rdata(line_rdata1), .done(done1),
      .mem_addr(mem_addr1), .mem_re(mem_re1), .mem_we(mem_we1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .mem_ack(mem_ack));

   cache_line_burst_adapter #(.WORD_SIZE(64), .WORDS_PER_LINE(4), .ADDR_WIDTH(32), .CRIT_WORD_FIRST(0)) dut2 (
      .clk(clk), .clr(clr), .req_valid(req_valid2), .req_ready(req_ready2), .req_wb(req_wb2),
      .req_addr(req_addr2), .line_wdata(line_wdata2), .line_rdata(line_rdata2), .done(done2),
      .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_we(mem_we2), .mem_wdata(mem_wdata2),
      .mem_rdata(mem_rdata2), .mem_ack(mem_ack2));

   // Memory contents are a fixed function of the word address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [63:0] memWord64(input logic [31:0] a);
      return {~a, a};
   endfunction

   always_comb mem_rdata0 = memWord(mem_addr0);
   always_comb mem_rdata1 = memWord(mem_addr1);
   always_comb mem_rdata2 = memWord64(mem_addr2);

   task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic checkQuiet(input string tag, input logic expDone);
      checkOutput({tag, " ready0"}, 256'(req_ready0), 256'(!expDone));
      checkOutput({tag, " ready1"}, 256'(req_ready1), 256'(!expDone));
      checkOutput({tag, " done0"},  256'(done0),      256'(expDone));
      checkOutput({tag, " done1"},  256'(done1),      256'(expDone));
      checkOutput({tag, " strobes0"}, 256'({mem_re0, mem_we0}), 256'(0));
      checkOutput({tag, " strobes1"}, 256'({mem_re1, mem_we1}), 256'(0));
      checkOutput({tag, " addr0"},  256'(mem_addr0),  256'(0));
      checkOutput({tag, " addr1"},  256'(mem_addr1),  256'(0));
      checkOutput({tag, " wdata0"}, 256'(mem_wdata0), 256'(0));
      checkOutput({tag, " wdata1"}, 256'(mem_wdata1), 256'(0));
   endtask

   // ackMode: 0 = ack every cycle, 1 = ack every third cycle, 2 = random acks.
   task automatic applyStimulus(input logic wb, input logic [31:0] addr, input int ackMode);
      logic [255:0] wdat, expLine;
      logic [31:0]  base;
      int           start1, idx0, idx1, k, cyc;
      logic         ack;
      @(negedge clk);
      checkQuiet("idle-pre", 1'b0);
      for (int i = 0; i < N; i++) wdat[i*32 +: 32] = $urandom;
      line_wdata = wdat;
      req_valid  = 1'b1;
      req_wb     = wb;
      req_addr   = addr;
      mem_ack    = 1'($urandom_range(0, 1));
      base   = addr & ~32'h1F;
      start1 = wb ? 0 : int'((addr >> 2) & 32'h7);
      k   = 0;
      cyc = 0;
      while (k < N) begin
         @(negedge clk);
         cyc++;
         idx0 = k;
         idx1 = (start1 + k) % N;
         checkOutput("busy ready0", 256'(req_ready0), 256'(0));
         checkOutput("busy done0",  256'(done0),      256'(0));
         checkOutput("busy done1",  256'(done1),      256'(0));
         checkOutput("busy re0", 256'(mem_re0), 256'(!wb));
         checkOutput("busy we0", 256'(mem_we0), 256'(wb));
         checkOutput("busy re1", 256'(mem_re1), 256'(!wb));
         checkOutput("busy we1", 256'(mem_we1), 256'(wb));
         checkOutput("busy addr0", 256'(mem_addr0), 256'(base + 32'(idx0 * 4)));
         checkOutput("busy addr1", 256'(mem_addr1), 256'(base + 32'(idx1 * 4)));
         checkOutput("busy wdata0", 256'(mem_wdata0), wb ? 256'(wdat[idx0*32 +: 32]) : 256'(0));
         checkOutput("busy wdata1", 256'(mem_wdata1), wb ? 256'(wdat[idx1*32 +: 32]) : 256'(0));
         req_valid = 1'($urandom_range(0, 1));
         req_addr  = $urandom;
         req_wb    = 1'($urandom_range(0, 1));
         if (wb) line_wdata = {8{$urandom}};
         case (ackMode)
            0:       ack = 1'b1;
            1:       ack = (cyc % 3 == 0);
            default: ack = ($urandom_range(0, 2) != 0) || (cyc > 60);
         endcase
         mem_ack = ack;
         if (ack) k++;
      end
      @(negedge clk);
      checkQuiet("done", 1'b1);
      req_valid = 1'($urandom_range(0, 1));
      mem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkQuiet("idle-post", 1'b0);
      if (wb) begin
         expLine = wdat;
      end else begin
         for (int i = 0; i < N; i++) expLine[i*32 +: 32] = memWord(base + 32'(i * 4));
      end
      checkOutput("line0", line_rdata0, expLine);
      checkOutput("line1", line_rdata1, expLine);
      req_valid = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
   endtask

   task automatic resetMidFill(input logic [31:0] addr);
      logic [31:0] base;
      base = addr & ~32'h1F;
      @(negedge clk);
      checkQuiet("idle-prerst", 1'b0);
      req_valid = 1'b1;
      req_wb    = 1'b0;
      req_addr  = addr;
      mem_ack   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         mem_ack   = 1'b1;
      end
      @(negedge clk);
      checkOutput("rst beat3 addr0", 256'(mem_addr0), 256'(base + 32'd12));
      clr       = 1'b1;
      req_valid = 1'b1;
      mem_ack   = 1'b1;
      @(negedge clk);
      clr       = 1'b0;
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      checkQuiet("after-rst", 1'b0);
   endtask

   task automatic runWide(input logic [31:0] addr);
      logic [31:0]  base;
      logic [255:0] expLine;
      base = addr & ~32'h1F;
      @(negedge clk);
      checkOutput("wide ready", 256'(req_ready2), 256'(1));
      req_valid2 = 1'b1;
      req_wb2    = 1'b0;
      req_addr2  = addr;
      mem_ack2   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid2 = 1'b0;
         mem_ack2   = 1'b1;
         checkOutput("wide re",   256'(mem_re2),   256'(1));
         checkOutput("wide addr", 256'(mem_addr2), 256'(base + 32'(k * 8)));
         checkOutput("wide done", 256'(done2),     256'(0));
      end
      @(negedge clk);
      mem_ack2 = 1'b0;
      checkOutput("wide done pulse", 256'(done2), 256'(1));
      checkOutput("wide addr zero",  256'(mem_addr2), 256'(0));
      @(negedge clk);
      checkOutput("wide done end", 256'(done2), 256'(0));
      for (int i = 0; i < 4; i++) expLine[i*64 +: 64] = memWord64(base + 32'(i * 8));
      checkOutput("wide line", line_rdata2, expLine);
   endtask

   initial begin
      clr         = 1'b1;
      req_valid   = 1'b0;
      req_wb      = 1'b0;
      req_addr    = '0;
      line_wdata  = '0;
      mem_ack     = 1'b0;
      req_valid2  = 1'b0;
      req_wb2     = 1'b0;
      req_addr2   = '0;
      line_wdata2 = '0;
      mem_ack2    = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      applyStimulus(1'b0, 32'h0000_1234, 0);
      applyStimulus(1'b1, 32'h0000_1234, 1);
      resetMidFill($urandom);
      applyStimulus(1'b0, 32'h0000_1234, 2);
      for (int t = 0; t < 20; t++)
         applyStimulus(1'($urandom_range(0, 1)), $urandom, t % 3);
      runWide(32'hFFFF_FFE8);
      runWide($urandom);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_line_burst_adapter.md
CACHE_LINE_BURST_ADAPTER -- requirements
Module: cache_line_burst_adapter

Interface
REQ-001 Parameter WORD_SIZE, default 32: data word width in bits, multiple of 8.
REQ-002 Parameter WORDS_PER_LINE, default 8: words per cache line, power of two, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-004 Parameter CRIT_WORD_FIRST, default 0: when 1, fills start at the requested word and wrap around the line.
REQ-005 Derived: BYTE_BITS = log2(WORD_SIZE/8); LINE_BITS = log2(WORDS_PER_LINE); OFFSET_BITS = BYTE_BITS + LINE_BITS.
REQ-006 Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- req_valid  in  1  cache requests a line transfer.
- req_ready  out  1  adapter can accept a request.
- req_wb  in  1  transfer mode: 1 = writeback, 0 = fill.
- req_addr  in  ADDR_WIDTH  byte address inside the target line.
- line_wdata  in  WORD_SIZE*WORDS_PER_LINE  line to write back; word i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- line_rdata  out  WORD_SIZE*WORDS_PER_LINE  filled line, same packing.
- done  out  1  one-cycle pulse marking transfer completion.
- mem_addr  out  ADDR_WIDTH  memory word byte address.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  WORD_SIZE  memory write data.
- mem_rdata  in  WORD_SIZE  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completes the current beat.

Function
REQ-007 FSM states are IDLE, FILL, WB and DONE.
REQ-008 req_ready SHALL be 1 only in IDLE.
REQ-009 Accept (IDLE, req_valid=1) SHALL capture base = req_addr with the low OFFSET_BITS bits forced to 0.
REQ-010 Accept SHALL capture mode, clear beat counter, and go to WB when req_wb=1, else FILL.
REQ-011 On a WB accept, all words of line_wdata SHALL load into the line buffer in the same cycle; later changes to line_wdata are ignored.
REQ-012 Word index: FILL with CRIT_WORD_FIRST=1 starts at req_addr[OFFSET_BITS-1:BYTE_BITS]; all other cases start at 0.
REQ-013 The word index SHALL increment modulo WORDS_PER_LINE on each mem_ack, wrapping from WORDS_PER_LINE-1 to 0.
REQ-014 mem_addr SHALL equal base + (index << BYTE_BITS), truncated to ADDR_WIDTH, and SHALL be 0 in IDLE and DONE.
REQ-015 In FILL, mem_re=1 and mem_we=0; on mem_ack, buffer[index] <= mem_rdata and the beat counter increments.
REQ-016 In WB, mem_we=1, mem_re=0 and mem_wdata=buffer[index]; on mem_ack, the beat counter increments.
REQ-017 mem_wdata SHALL be 0 outside WB.
REQ-018 Strobes and mem_addr SHALL hold stable until mem_ack; with mem_ack held high, the adapter completes one beat per cycle.
REQ-019 On the mem_ack of beat WORDS_PER_LINE-1, the adapter SHALL go to DONE and drop strobes in the next cycle.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-021 Minimum latency from accept to done is WORDS_PER_LINE+1 cycles.
REQ-022 line_rdata SHALL continuously reflect the line buffer and is valid from the DONE cycle of a FILL until the next accept.
REQ-023 mem_ack in IDLE or DONE, and req_valid outside IDLE, SHALL be ignored with no state change.

Reset
REQ-024 With clr=1 at a rising edge, the FSM SHALL enter IDLE and clear the beat counter and index, including mid-transfer.
REQ-025 From the cycle after reset, outputs SHALL be req_ready=1, done=0, mem_re=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-026 clr SHALL NOT clear the line buffer; line_rdata content after reset is unspecified until a fill completes.
REQ-027 clr SHALL take priority over every other input in the same cycle.

Verification
REQ-028 Fill, defaults, req_addr=0x0000_1234, mem_ack always 1, mem_rdata=index+0x100 -> mem_addr 0x1220..0x123C in order; done on cycle 9 after accept; word i of line_rdata = 0x100+i.
REQ-029 Fill, CRIT_WORD_FIRST=1, req_addr=0x0000_1234 -> mem_addr order 0x1234, 0x1238, 0x123C, 0x1220 .. 0x1230; each word stored at its own index.
REQ-030 Writeback, line_wdata word i = 0xA0+i, mem_ack high every third cycle -> mem_we held with stable addr/data between acks; eight beats with data 0xA0..0xA7; single done pulse.
REQ-031 clr asserted after 3 fill beats -> next cycle IDLE, req_ready=1, strobes 0, no done; a new request restarts at beat 0.
REQ-032 req_valid during FILL and stray mem_ack in IDLE -> ignored; beat count, index and outputs unchanged.
REQ-033 WORDS_PER_LINE=4, WORD_SIZE=64, req_addr=0xFFFF_FFE8 -> base 0xFFFF_FFE0; addresses 0xFFFF_FFE0..0xFFFF_FFF8 without carry out.
